// File: rtl/timebase_timer.sv
// timebase_timer
//   Exact-period tick generator, free-running elapsed-tick counter and N_CH
//   independent one-shot countdown timers that count in ticks.
//
//   Optional build macro: TIMEBASE_SATURATE_EN
//     defined   -> time_out sticks at all-ones until clr or rst
//     undefined -> time_out wraps to zero
//
//   Ports
//     clk       system clock
//     rst       asynchronous, active-high reset
//     clr       synchronous clear of prescaler, tick and time_out
//     pause     freezes prescaler, time_out and channel counts
//     tick      one-cycle pulse every DIV unpaused cycles
//     time_out  elapsed ticks since reset or clr
//     start     per-channel load/start strobe
//     cancel    per-channel abort strobe
//     load_val  channel i load value at [i*TMR_W +: TMR_W]
//     busy      channel is counting
//     expired   one-cycle pulse when a channel reaches zero
//     remain    remaining ticks per channel, packed like load_val
//
//   Channel FSM
//     state | meaning
//     IDLE  | not counting, remain = 0
//     RUN   | counting down on each tick, remain >= 1
module timebase_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 32,
  parameter int N_CH    = 2,
  parameter int TMR_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    pause,
  output logic                    tick,
  output logic [CNT_W-1:0]        time_out,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         cancel,
  input  logic [N_CH*TMR_W-1:0]   load_val,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         expired,
  output logic [N_CH*TMR_W-1:0]   remain
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] time_q, time_d, time_inc;

  state_e           state_q  [N_CH];
  state_e           state_d  [N_CH];
  logic [TMR_W-1:0] remain_q [N_CH];
  logic [TMR_W-1:0] remain_d [N_CH];
  logic [N_CH-1:0]  expired_q, expired_d;

`ifdef TIMEBASE_SATURATE_EN
  assign time_inc = (&time_q) ? time_q : time_q + 1'b1;
`else
  assign time_inc = time_q + 1'b1;
`endif

  // clr beats pause and a coincident wrap
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    time_d = time_q;
    if (clr) begin
      pre_d  = '0;
      time_d = '0;
    end else if (!pause) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        time_d = time_inc;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      time_q <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      time_q <= time_d;
    end
  end

  // Channels consume the registered tick, so a start landing in a tick
  // cycle reloads and that tick is not counted. Pause also masks a tick
  // that is already in flight so the counts truly freeze.
  always_comb begin
    expired_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      remain_d[i] = remain_q[i];
      if (start[i]) begin
        if (load_val[i*TMR_W +: TMR_W] != '0) begin
          state_d[i]  = RUN;
          remain_d[i] = load_val[i*TMR_W +: TMR_W];
        end else begin
          state_d[i]   = IDLE;
          remain_d[i]  = '0;
          expired_d[i] = 1'b1;
        end
      end else if (cancel[i]) begin
        state_d[i]  = IDLE;
        remain_d[i] = '0;
      end else if (state_q[i] == RUN && tick_q && !pause) begin
        if (remain_q[i] == TMR_W'(1)) begin
          state_d[i]   = IDLE;
          remain_d[i]  = '0;
          expired_d[i] = 1'b1;
        end else begin
          remain_d[i] = remain_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expired_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= IDLE;
        remain_q[i] <= '0;
      end
    end else begin
      expired_q <= expired_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
      end
    end
  end

  always_comb begin
    busy   = '0;
    remain = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy[i]                   = (state_q[i] == RUN);
      remain[i*TMR_W +: TMR_W]  = remain_q[i];
    end
  end

  assign tick     = tick_q;
  assign time_out = time_q;
  assign expired  = expired_q;

endmodule
